// File: rtl/matrix_vector_loader.sv
// matrix_vector_loader
// Serial-to-parallel input stage for the sequential 4x4 matrix-vector product unit.
// Collects a 20-word frame (16 row-major matrix elements, then 4 vector elements)
// from a valid/ready stream into a load bank. When a frame is complete, the frame
// is copied into an output bank that stays stable while the product unit computes.
// Because there are two banks, the next frame can load while the current one is in use.
//
// Ports:
//   clk                  clock, rising edge
//   rst                  asynchronous active-low reset
//   s_data/s_valid/s_last/s_ready  input word stream
//   mat_0_0..mat_3_3     matrix outputs (row r = idx/4, column c = idx%4)
//   vector_0..vector_3   vector outputs
//   m_valid/m_ready      handshake with the product unit (i_valid / i_ready)
//   err_count            saturating count of malformed frames
module matrix_vector_loader #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  real              s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output real              mat_0_0, mat_0_1, mat_0_2, mat_0_3,
  output real              mat_1_0, mat_1_1, mat_1_2, mat_1_3,
  output real              mat_2_0, mat_2_1, mat_2_2, mat_2_3,
  output real              mat_3_0, mat_3_1, mat_3_2, mat_3_3,
  output real              vector_0, vector_1, vector_2, vector_3,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    O_EMPTY    = 2'd0,
    O_VALID    = 2'd1,
    O_ACCEPTED = 2'd2,
    O_BUSY     = 2'd3
  } out_state_t;

  out_state_t       out_state_r, out_state_s;
  real              load_r [20];
  real              out_r  [20];
  logic [4:0]       idx_r;
  logic             full_r;
  logic [ERR_W-1:0] err_count_r;
  logic             m_valid_r;
  logic             accept_s, last_pos_s, good_s, bad_s, copy_s;

  // Word acceptance, frame-boundary classification and the bank-copy condition.
  always_comb begin
    accept_s   = 1'b0;
    last_pos_s = 1'b0;
    good_s     = 1'b0;
    bad_s      = 1'b0;
    copy_s     = 1'b0;
    accept_s   = s_valid && !full_r;
    last_pos_s = (idx_r == 5'd19);
    good_s     = accept_s && last_pos_s && s_last;
    // s_last must coincide exactly with position 19; any disagreement is malformed.
    bad_s      = accept_s && (s_last != last_pos_s);
    copy_s     = (out_state_r == O_EMPTY) && full_r;
  end

  // Output-bank next-state logic.
  always_comb begin
    out_state_s = out_state_r;
    case (out_state_r)
      O_EMPTY: begin
        if (full_r) out_state_s = O_VALID;
        else        out_state_s = O_EMPTY;
      end
      O_VALID: begin
        if (m_ready) out_state_s = O_ACCEPTED;
        else         out_state_s = O_VALID;
      end
      // The product unit drops i_ready once it starts computing.
      O_ACCEPTED: begin
        if (!m_ready) out_state_s = O_BUSY;
        else          out_state_s = O_ACCEPTED;
      end
      // i_ready returning high means the product unit is idle again.
      O_BUSY: begin
        if (m_ready) out_state_s = O_EMPTY;
        else         out_state_s = O_BUSY;
      end
      default: out_state_s = O_EMPTY;
    endcase
  end

  // Output-bank state register; m_valid is registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_state_r <= O_EMPTY;
      m_valid_r   <= 1'b0;
    end else begin
      out_state_r <= out_state_s;
      m_valid_r   <= (out_state_s == O_VALID);
    end
  end

  // Load bank: word storage, position counter, full flag and error counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 20; i++) load_r[i] <= 0.0;
      idx_r       <= 5'd0;
      full_r      <= 1'b0;
      err_count_r <= {ERR_W{1'b0}};
    end else begin
      if (accept_s) begin
        load_r[idx_r] <= s_data;
        if (good_s || bad_s) idx_r <= 5'd0;
        else                 idx_r <= idx_r + 5'd1;
      end
      // A copy only happens while full, and no word is accepted while full.
      if (good_s)      full_r <= 1'b1;
      else if (copy_s) full_r <= 1'b0;
      if (bad_s && (err_count_r != {ERR_W{1'b1}})) err_count_r <= err_count_r + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  end

  // Output bank: the only place the presented data changes is the copy edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 20; i++) out_r[i] <= 0.0;
    end else if (copy_s) begin
      for (int i = 0; i < 20; i++) out_r[i] <= load_r[i];
    end
  end

  assign s_ready   = !full_r;
  assign m_valid   = m_valid_r;
  assign err_count = err_count_r;

  assign mat_0_0  = out_r[0];  assign mat_0_1  = out_r[1];
  assign mat_0_2  = out_r[2];  assign mat_0_3  = out_r[3];
  assign mat_1_0  = out_r[4];  assign mat_1_1  = out_r[5];
  assign mat_1_2  = out_r[6];  assign mat_1_3  = out_r[7];
  assign mat_2_0  = out_r[8];  assign mat_2_1  = out_r[9];
  assign mat_2_2  = out_r[10]; assign mat_2_3  = out_r[11];
  assign mat_3_0  = out_r[12]; assign mat_3_1  = out_r[13];
  assign mat_3_2  = out_r[14]; assign mat_3_3  = out_r[15];
  assign vector_0 = out_r[16]; assign vector_1 = out_r[17];
  assign vector_2 = out_r[18]; assign vector_3 = out_r[19];

endmodule

// File: tb/tb_matrix_vector_loader.sv
// Directed testbench for matrix_vector_loader. Inputs are driven and outputs
// sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_matrix_vector_loader;

  logic       clk;
  logic       rst;
  real        s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  real        mat_o [16];
  real        vec_o [4];
  logic       m_valid;
  logic       m_ready;
  logic [7:0] err_count;

  int n_tests;
  int n_fail;

  matrix_vector_loader #(.ERR_W(8)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .mat_0_0(mat_o[0]),  .mat_0_1(mat_o[1]),  .mat_0_2(mat_o[2]),  .mat_0_3(mat_o[3]),
    .mat_1_0(mat_o[4]),  .mat_1_1(mat_o[5]),  .mat_1_2(mat_o[6]),  .mat_1_3(mat_o[7]),
    .mat_2_0(mat_o[8]),  .mat_2_1(mat_o[9]),  .mat_2_2(mat_o[10]), .mat_2_3(mat_o[11]),
    .mat_3_0(mat_o[12]), .mat_3_1(mat_o[13]), .mat_3_2(mat_o[14]), .mat_3_3(mat_o[15]),
    .vector_0(vec_o[0]), .vector_1(vec_o[1]), .vector_2(vec_o[2]), .vector_3(vec_o[3]),
    .m_valid(m_valid), .m_ready(m_ready), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input real got, input real exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %f expected %f", tag, got, exp);
    end
  endtask

  // Offer one word, starting and ending on a falling edge; wait while s_ready is low.
  task automatic send_word(input real d, input logic last);
    logic rdy;
    bit   done;
    done    = 1'b0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    for (int g = 0; g < 200 && !done; g++) begin
      rdy = s_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy) done = 1'b1;
    end
    if (!done) check("send_word timeout", 0.0, 1.0);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Send n consecutive values starting at base, with s_last on position last_pos.
  task automatic send_frame(input real base, input int n, input int last_pos);
    for (int i = 0; i < n; i++) send_word(base + i, (i == last_pos));
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int g = 0; g < 50 && !seen; g++) begin
      if (m_valid) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) check(tag, 0.0, 1.0);
  endtask

  // Handshake with m_ready high, then one busy cycle, ending in the empty state.
  task automatic complete_cycle();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
  endtask

  real y [4];
  real snap0;
  bit  stable;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    s_data  = 0.0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;

    // 1. Asynchronous reset mid-cycle
    #3 rst = 1'b0;
    #1;
    check("rst m_valid", m_valid, 0.0);
    check("rst s_ready", s_ready, 1.0);
    check("rst err_count", err_count, 0.0);
    check("rst mat_0_0", mat_o[0], 0.0);
    check("rst vector_3", vec_o[3], 0.0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 2. Single frame 1..20
    send_frame(1.0, 20, 19);
    check("f1 s_ready full", s_ready, 0.0);
    check("f1 m_valid before copy", m_valid, 0.0);
    @(negedge clk);
    check("f1 m_valid", m_valid, 1.0);
    check("f1 s_ready after copy", s_ready, 1.0);
    check("f1 mat_0_0", mat_o[0], 1.0);
    check("f1 mat_1_2", mat_o[6], 7.0);
    check("f1 mat_3_3", mat_o[15], 16.0);
    check("f1 vector_0", vec_o[0], 17.0);
    check("f1 vector_3", vec_o[3], 20.0);
    @(negedge clk);
    check("f1 m_valid after hs", m_valid, 0.0);
    m_ready = 1'b0;
    @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);

    // 3. Identity matrix with vector (1,2,3,4) against a product-unit model
    for (int k = 0; k < 16; k++) send_word((k % 5 == 0) ? 1.0 : 0.0, 1'b0);
    for (int k = 0; k < 4; k++) send_word(k + 1.0, (k == 3));
    wait_valid("pu wait m_valid");
    @(negedge clk);
    check("pu m_valid after hs", m_valid, 0.0);
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) y[k] = 0.0;
    snap0  = mat_o[0];
    stable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      y[k / 4] = y[k / 4] + mat_o[k] * vec_o[k % 4];
      if (m_valid || mat_o[0] != snap0 || vec_o[3] != 4.0) stable = 1'b0;
    end
    m_ready = 1'b1;
    @(negedge clk);
    check("pu stable", stable, 1.0);
    check("pu y0", y[0], 1.0);
    check("pu y1", y[1], 2.0);
    check("pu y2", y[2], 3.0);
    check("pu y3", y[3], 4.0);

    // 4. Double buffer: second frame loads while the product unit computes
    send_frame(1.0, 20, 19);
    @(negedge clk);
    check("db m_valid A", m_valid, 1.0);
    @(negedge clk);
    m_ready = 1'b0;
    @(negedge clk);
    send_frame(21.0, 20, 19);
    check("db s_ready full", s_ready, 0.0);
    check("db mat_0_0 held", mat_o[0], 1.0);
    repeat (3) @(negedge clk);
    check("db s_ready still full", s_ready, 0.0);
    check("db m_valid busy", m_valid, 0.0);
    m_ready = 1'b1;
    @(negedge clk);
    check("db m_valid at empty", m_valid, 0.0);
    check("db mat_0_0 before copy", mat_o[0], 1.0);
    @(negedge clk);
    check("db m_valid B", m_valid, 1.0);
    check("db mat_0_0 B", mat_o[0], 21.0);
    check("db vector_3 B", vec_o[3], 40.0);
    check("db s_ready after copy", s_ready, 1.0);
    complete_cycle();

    // 5. Malformed frames
    send_frame(100.0, 6, 5);
    check("err early last count", err_count, 1.0);
    check("err early last s_ready", s_ready, 1.0);
    check("err early last m_valid", m_valid, 0.0);
    send_frame(110.0, 20, 99);
    repeat (2) @(negedge clk);
    check("err missing last count", err_count, 2.0);
    check("err missing last m_valid", m_valid, 0.0);
    send_frame(41.0, 20, 19);
    wait_valid("err good wait m_valid");
    check("err good mat_0_0", mat_o[0], 41.0);
    check("err good mat_1_2", mat_o[6], 47.0);
    check("err good vector_3", vec_o[3], 60.0);
    complete_cycle();

    // 6. Reset in the middle of a frame
    send_frame(200.0, 10, 99);
    #2 rst = 1'b0;
    #1;
    check("mid rst mat_0_0", mat_o[0], 0.0);
    check("mid rst err_count", err_count, 0.0);
    check("mid rst s_ready", s_ready, 1.0);
    #1 rst = 1'b1;
    @(negedge clk);
    send_frame(61.0, 20, 19);
    wait_valid("mid rst wait m_valid");
    check("mid rst mat_0_0 new", mat_o[0], 61.0);
    check("mid rst mat_2_1 new", mat_o[9], 70.0);
    check("mid rst vector_0 new", vec_o[0], 77.0);
    check("mid rst err stays", err_count, 0.0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_vector_loader.md
# matrix_vector_loader

Serial-to-parallel input stage that sits directly upstream of the sequential 4x4 matrix-vector product unit. It accepts a frame of 20 real-valued words one per cycle over a valid/ready stream: 16 matrix elements in row-major order, then 4 vector elements. It presents the frame as 20 parallel registered outputs with a valid flag that drives the product unit's `i_valid`. The block double-buffers so the next frame can load while the product unit is still consuming the current one, and it holds its outputs stable until the product unit returns to idle.

## Interface
- `ERR_W`, default 8: width of the frame-error counter.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `s_data`  in  real: input word.
- `s_valid`  in  1: `s_data` is valid.
- `s_last`  in  1: marks the final word of a frame.
- `s_ready`  out  1: loader can accept a word.
- `mat_0_0` .. `mat_3_3`  out  real: 16 matrix outputs; connect to the product unit's `mat_r_c`.
- `vector_0` .. `vector_3`  out  real: 4 vector outputs.
- `m_valid`  out  1: output bank holds a frame not yet accepted; drives the product unit's `i_valid`.
- `m_ready`  in  1: driven by the product unit's `i_ready`.
- `err_count`  out  `ERR_W`: saturating count of malformed frames.

## Operation
- **Load bank.**
  - Holds 20 real registers, a 5-bit word counter `idx` (0..19) and a `full` flag.
  - `s_ready` = `!full` (combinational).
  - A word is accepted when `s_valid && s_ready`. Word `idx` is stored at position `idx`, then `idx` increments.
  - Positions 0..15 map to `mat_r_c` with r = idx/4 and c = idx%4. Positions 16..19 map to `vector_0..3`.
- **Framing.**
  - Good frame: `s_last` is high on the word accepted at `idx`==19. That edge sets `full` and resets `idx` to 0.
  - Error case 1: `s_last` is high on an accepted word with `idx`<19.
  - Error case 2: `s_last` is low on the accepted word at `idx`==19.
  - On either error: the partial frame is discarded, `idx` goes to 0, `full` stays 0, and `err_count` increments (saturating at 2^ERR_W-1).
- **Output bank FSM** (`out_state`):
  - **O_EMPTY**, `m_valid`=0. If `full`=1: copy all 20 load registers into the output registers, clear `full`, go to O_VALID. The same edge may accept no word, because `s_ready` was 0.
  - **O_VALID**, `m_valid`=1. If `m_ready`=1, the handshake completes and the FSM goes to O_ACCEPTED.
  - **O_ACCEPTED**, `m_valid`=0. If `m_ready`=0 (product unit has entered compute), go to O_BUSY. Otherwise stay.
  - **O_BUSY**, `m_valid`=0. If `m_ready`=1 (product unit is back in idle), go to O_EMPTY.
  - Any unreachable encoding returns to O_EMPTY.
- Output data registers change only on the O_EMPTY copy edge. They are stable through O_VALID, O_ACCEPTED and O_BUSY.
- The load bank keeps filling in every output state. It stalls only while `full`=1.

## Timing
- **Reset** (`rst`=0, asynchronous, any cycle including mid-frame):
  - `idx`=0, `full`=0, `out_state`=O_EMPTY.
  - All 20 data outputs = 0.0, `err_count`=0.
  - Hence `s_ready`=1 and `m_valid`=0.
  - Any partial frame is lost. Deassertion takes effect at the next rising edge.
- **Latency.**
  - The 20th word is accepted on edge E. `full`=1 after E.
  - If `out_state`=O_EMPTY after E, the copy happens on E+1 and `m_valid`=1 after E+1.
  - With continuous `s_valid`, a frame starting at edge 0 gives `m_valid` high after edge 20.
- **Throughput.** One accepted word per cycle, plus one stall cycle per frame (the `full` cycle before the copy).
- **Handshake.**
  - `m_valid` does not depend combinationally on `m_ready`.
  - Once asserted, `m_valid` stays high, with the data stable, until `m_ready`=1 is sampled.
  - `m_valid` deasserts on the edge after that.
- **Simultaneous events.**
  - O_BUSY→O_EMPTY on the same edge that sets `full`: the copy occurs on the following edge.
  - An error and saturation on the same edge: `err_count` holds at its maximum.
- If `full`=1 and the output bank is busy, `s_ready` stays 0 indefinitely. Words offered meanwhile are not accepted, and the source must hold them.

## Test plan
1. **Reset.** Assert `rst`=0 mid-cycle → immediately `m_valid`=0, `s_ready`=1, `err_count`=0, all outputs 0.0.
2. **Single frame.** Stream 1.0..20.0 continuously, `s_last` on the 20th word, `m_ready`=1 → `m_valid` rises after edge 20. Expect `mat_0_0`=1.0, `mat_1_2`=7.0, `mat_3_3`=16.0, `vector_0`=17.0, `vector_3`=20.0. `m_valid` falls one cycle after the handshake.
3. **Against the product unit model.** Load matrix = identity, vector = (1,2,3,4) → outputs stay stable through 16 compute cycles plus done. The product unit reports (1,2,3,4).
4. **Double-buffer.** A second frame 21.0..40.0 streams during compute → `s_ready` drops after its 20th word. The copy happens only after `m_ready` returns to 1, then `mat_0_0`=21.0.
5. **Malformed frames.**
   - `s_last` on word 6 → `err_count`=1, `idx`=0, no `m_valid`.
   - Then 20 words with `s_last` low on word 20 → `err_count`=2, no `m_valid`.
   - A following good frame presents correctly.
6. **Reset mid-frame.** Pulse `rst` after 10 words → `idx`=0. A fresh 20-word frame presents only its own values.
